// File: rtl/x_pulse_conditioner.sv
// x_pulse_conditioner: synchronizes and debounces a raw asynchronous level and
// produces a single-cycle registered advance strobe (x) per qualified press,
// plus the debounced level and a busy flag for status display.
// Optional build macro: AUTO_REPEAT_EN -- while the input stays held, x
// re-pulses every REPEAT_CYCLES cycles.
module x_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_CYCLES   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic x,
    output logic level,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on the legal parameter ranges
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..65535");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_repeat
        $error("REPEAT_CYCLES out of range 2..65535");
    end

    typedef enum logic [3:0] {
        IDLE         = 4'b0001,
        PRESS_WAIT   = 4'b0010,
        HELD         = 4'b0100,
        RELEASE_WAIT = 4'b1000
    } state_e;

    logic          sync1_q, sync2_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          x_q, level_q, busy_q;
    logic          s;

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_q;
`endif

    assign s     = sync2_q;
    assign x     = x_q;
    assign level = level_q;
    assign busy  = busy_q;

    // Two-flop synchronizer bringing raw_in into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM; outputs are registered alongside each transition. Abort on
    // s mismatch is tested before count completion in both wait states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            x_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        x_q     <= 1'b1;
                        level_q <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
                        rpt_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
`ifdef AUTO_REPEAT_EN
                    // Period counts from the last x pulse or HELD entry
                    else if (rpt_q == RPT_LAST) begin
                        x_q   <= 1'b1;
                        rpt_q <= '0;
                    end else begin
                        rpt_q <= rpt_q + RW'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        // Release bounce: back to HELD without a new pulse
                        state_q <= HELD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
                        rpt_q   <= '0;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_pulse_conditioner.sv
// Scoreboard bench for x_pulse_conditioner: stimulus pushes the expected edge
// numbers of x pulses and of level/busy transitions; a monitor pops and
// compares whenever the DUT output pulses or changes.
module tb_x_pulse_conditioner;

    localparam int D   = 8;
    localparam int RPT = 32;
`ifdef AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b0;
    logic x, level, busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int xq[$];
    int lq[$];
    int bq[$];
    logic [6:0] ring = 7'b0000001;

    x_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(RPT)) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in), .x(x), .level(level), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at edge %0d, expected none", name, cyc);
    endtask

    // Monitor: sample 1 time unit after each rising edge; cyc = edge number
    initial begin
        logic pl, pb;
        pl = 1'b0;
        pb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pl = level;
                pb = busy;
            end else begin
                if (x !== 1'b0) begin
                    if (xq.size() == 0) unexpected("x_pulse");
                    else chk("x_pulse_edge", cyc, xq.pop_front());
                    ring = {ring[5:0], ring[6]};
                end
                if (level !== pl) begin
                    if (lq.size() == 0) unexpected("level_change");
                    else chk("level_change_edge", cyc, lq.pop_front());
                end
                if (busy !== pb) begin
                    if (bq.size() == 0) unexpected("busy_change");
                    else chk("busy_change_edge", cyc, bq.pop_front());
                end
                pl = level;
                pb = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // raw_in high before edge n
    task automatic push_press(input int n);
        bq.push_back(n + 2);
        bq.push_back(n + D + 2);
        lq.push_back(n + D + 2);
        xq.push_back(n + D + 2);
    endtask

    // Repeat pulses while HELD from entry edge e through edge last
    task automatic push_repeats(input int e, input int last);
        if (REP_EN) begin
            for (int k = e + RPT; k <= last; k += RPT) xq.push_back(k);
        end
    endtask

    // raw_in low (final) before edge m
    task automatic push_release(input int m);
        bq.push_back(m + 2);
        bq.push_back(m + D + 2);
        lq.push_back(m + D + 2);
    endtask

    task automatic clean_press(input int hold);
        int c;
        c = cyc;
        push_press(c + 1);
        push_repeats(c + D + 3, c + hold + 2);
        push_release(c + hold + 1);
        raw_in = 1'b1;
        tick(hold);
        raw_in = 1'b0;
        tick(D + 8);
    endtask

    initial begin
        int c, q, r;
        // Reset state
        tick(3);
        chk("reset_x", x, 0);
        chk("reset_level", level, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        tick(4);

        // Reset mid-PRESS_WAIT, raw_in kept high across reset
        c = cyc;
        bq.push_back(c + 3);
        raw_in = 1'b1;
        tick(5);
        #2 rst = 1'b1;
        #1;
        chk("midrst_x", x, 0);
        chk("midrst_level", level, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        q = cyc;
        push_press(q + 1);
        push_repeats(q + D + 3, q + 22);
        push_release(q + 21);
        tick(20);
        raw_in = 1'b0;
        tick(D + 8);

        // Clean press held long (repeat window when enabled)
        clean_press(130);

        // Press bounce 1,0,1,0,1,0 then stable high
        c = cyc;
        for (int i = 3; i <= 8; i++) bq.push_back(c + i);
        push_press(c + 7);
        push_repeats(c + 7 + D + 2, c + 28);
        push_release(c + 27);
        for (int i = 0; i < 6; i++) begin
            raw_in = (i % 2 == 0);
            tick(1);
        end
        raw_in = 1'b1;
        tick(20);
        raw_in = 1'b0;
        tick(D + 8);

        // Release bounce: low 3, high 2, then low
        c = cyc;
        r = c + 20;
        push_press(c + 1);
        push_repeats(c + D + 3, r + 2);
        bq.push_back(r + 3);
        bq.push_back(r + 6);
        push_release(r + 6);
        raw_in = 1'b1;
        tick(20);
        raw_in = 1'b0;
        tick(3);
        raw_in = 1'b1;
        tick(2);
        raw_in = 1'b0;
        tick(D + 8);

        // Integration: seven presses into a 7-state one-hot ring
        ring = 7'b0000001;
        for (int k = 1; k <= 7; k++) begin
            clean_press(15);
            chk("step_out", ring[0], (k == 7) ? 1 : 0);
        end

        tick(5);
        chk("x_queue_left", xq.size(), 0);
        chk("level_queue_left", lq.size(), 0);
        chk("busy_queue_left", bq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
